// File: rtl/multiplier.sv
// Shift-add multiply-accumulate: o_product = i_multiplicand * i_multiplier + i_addend, N+1 edges start->finished.
// Optional MULTIPLIER_EARLY_EXIT_EN stops iterating once the remaining multiplier bits are all zero.
module multiplier #(
  parameter int N = 8
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_start,
  output logic           o_busy,
  output logic           o_finished,
  input  logic [N-1:0]   i_multiplicand,
  input  logic [N-1:0]   i_multiplier,
  input  logic [N-1:0]   i_addend,
  output logic [2*N-1:0] o_product
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [2*N-1:0] acc_sum;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  count;
  logic           last_iter;

  // Carry out of the top bit is always zero: (2^N-1)^2 + 2^N-1 fits in 2N bits.
  always_comb begin
    acc_sum = mplier[0] ? (acc + mcand) : acc;
`ifdef MULTIPLIER_EARLY_EXIT_EN
    last_iter = (count == CW'(N - 1)) || (mplier[N-1:1] == '0);
`else
    last_iter = (count == CW'(N - 1));
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      o_product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            acc    <= {{N{1'b0}}, i_addend};
            mcand  <= {{N{1'b0}}, i_multiplicand};
            mplier <= i_multiplier;
            count  <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last_iter) begin
            o_product <= acc_sum;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy     = (state == RUN);
  assign o_finished = (state == DONE);

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for multiplier: scoreboard queues of expected products and latencies, checked at o_finished.
module tb_multiplier;

  localparam int N = 8;

  logic           i_clock = 1'b0;
  logic           i_reset = 1'b1;
  logic           i_start = 1'b0;
  logic           o_busy;
  logic           o_finished;
  logic [N-1:0]   i_multiplicand = '0;
  logic [N-1:0]   i_multiplier = '0;
  logic [N-1:0]   i_addend = '0;
  logic [2*N-1:0] o_product;

  int checks = 0;
  int errors = 0;

  logic [2*N-1:0] exp_q[$];
  int             lat_q[$];

  multiplier #(.N(N)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .o_busy         (o_busy),
    .o_finished     (o_finished),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .i_addend       (i_addend),
    .o_product      (o_product)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Edges from accept to the cycle where o_finished is seen.
  function automatic int exp_latency(input logic [N-1:0] m);
`ifdef MULTIPLIER_EARLY_EXIT_EN
    int msb;
    msb = 0;
    for (int i = 0; i < N; i++) if (m[i]) msb = i;
    return ((m == '0) ? 1 : msb + 1) + 1;
`else
    return N + 1;
`endif
  endfunction

  task automatic push_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
    exp_q.push_back((2*N)'(a) * (2*N)'(b) + (2*N)'(c));
    lat_q.push_back(exp_latency(b));
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c);
    int edges;
    int busy_cnt;
    int lat;
    logic seen;
    logic [2*N-1:0] exp;
    push_op(a, b, c);
    @(negedge i_clock);
    i_start = 1'b1;
    i_multiplicand = a;
    i_multiplier = b;
    i_addend = c;
    @(negedge i_clock);
    i_start = 1'b0;
    i_multiplicand = $urandom_range(0, 255);
    i_multiplier = $urandom_range(0, 255);
    i_addend = $urandom_range(0, 255);
    edges = 1;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (o_finished) begin
        seen = 1'b1;
      end else begin
        if (o_busy) busy_cnt++;
        @(negedge i_clock);
        edges++;
      end
    end
    exp = exp_q.pop_front();
    lat = lat_q.pop_front();
    check({tag, "_finished_seen"}, 32'(seen), 32'd1);
    check({tag, "_product"}, 32'(o_product), 32'(exp));
    check({tag, "_latency"}, 32'(edges), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
    @(negedge i_clock);
    check({tag, "_finished_pulse_1cyc"}, 32'(o_finished), 32'd0);
    check({tag, "_product_held"}, 32'(o_product), 32'(exp));
  endtask

  initial begin
    int cyc;
    int fin_cnt;
    int fin_cyc[2];
    logic saw_fin;
    logic [2*N-1:0] exp;

    // Reset state
    repeat (2) @(negedge i_clock);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_finished", 32'(o_finished), 32'd0);
    check("reset_product", 32'(o_product), 32'd0);
    i_reset = 1'b0;

    run_op("basic_11x13p7", 8'd11, 8'd13, 8'd7);
    run_op("max_255x255p255", 8'd255, 8'd255, 8'd255);
    run_op("zero_mcand_0x200p5", 8'd0, 8'd200, 8'd5);
    run_op("mplier1_9x1p2", 8'd9, 8'd1, 8'd2);
    run_op("mplier80_3x128p0", 8'd3, 8'h80, 8'd0);
    run_op("mplier0_5x0p3", 8'd5, 8'd0, 8'd3);

    // Back-to-back with i_start held high; second operands presented during RUN.
    push_op(8'd3, 8'd4, 8'd1);
    push_op(8'd6, 8'd7, 8'd0);
    @(negedge i_clock);
    i_start = 1'b1;
    i_multiplicand = 8'd3;
    i_multiplier = 8'd4;
    i_addend = 8'd1;
    @(negedge i_clock);
    i_multiplicand = 8'd6;
    i_multiplier = 8'd7;
    i_addend = 8'd0;
    fin_cnt = 0;
    fin_cyc[0] = 0;
    fin_cyc[1] = 0;
    for (cyc = 1; cyc < 60 && fin_cnt < 2; cyc++) begin
      if (o_finished) begin
        exp = exp_q.pop_front();
        void'(lat_q.pop_front());
        check("b2b_product", 32'(o_product), 32'(exp));
        fin_cyc[fin_cnt] = cyc;
        fin_cnt++;
        if (fin_cnt == 2) i_start = 1'b0;
      end
      @(negedge i_clock);
    end
    i_start = 1'b0;
    check("b2b_finish_count", 32'(fin_cnt), 32'd2);
    check("b2b_first_latency", 32'(fin_cyc[0]), 32'(exp_latency(8'd4)));
    check("b2b_gap", 32'(fin_cyc[1] - fin_cyc[0]), 32'(exp_latency(8'd7)));
    @(negedge i_clock);
    check("b2b_idle_after", 32'(o_busy | o_finished), 32'd0);

    // Reset mid-RUN: applied on iteration edge E4.
    @(negedge i_clock);
    i_start = 1'b1;
    i_multiplicand = 8'd100;
    i_multiplier = 8'd100;
    i_addend = 8'd0;
    @(negedge i_clock);
    i_start = 1'b0;
    repeat (3) @(negedge i_clock);
    check("pre_reset_busy", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    i_start = 1'b1;
    @(negedge i_clock);
    check("midrun_reset_busy", 32'(o_busy), 32'd0);
    check("midrun_reset_finished", 32'(o_finished), 32'd0);
    check("midrun_reset_product", 32'(o_product), 32'd0);
    i_reset = 1'b0;
    i_start = 1'b0;
    saw_fin = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (o_finished || o_busy) saw_fin = 1'b1;
      @(negedge i_clock);
    end
    check("midrun_reset_no_finish", 32'(saw_fin), 32'd0);
    run_op("after_reset_100x100p0", 8'd100, 8'd100, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multiplier.md
# multiplier

Sequential shift-add multiply-accumulate unit that computes o_product = i_multiplicand × i_multiplier + i_addend over N iterations. It is the inverse datapath of the divider: it rebuilds a dividend from quotient, divisor and remainder. It also serves as the general N×N multiplier for the arithmetic circuits. Control uses the same start/finished handshake as the other sequential arithmetic blocks, so the two can share one sequencer.

## Interface
- N, 8, operand width in bits; must be ≥ 2.
- i_clock  input  1  sole clock; all state changes on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request; sampled only when o_busy = 0.
- o_busy  output  1  high while iterating (state RUN).
- o_finished  output  1  one-cycle pulse; o_product valid from this cycle on.
- i_multiplicand  input  N  first factor (e.g. divisor).
- i_multiplier  input  N  second factor (e.g. quotient).
- i_addend  input  N  zero-extended addend (e.g. remainder).
- o_product  output  2N  registered result; held until the next completion.

## Operation
- States: IDLE, RUN, DONE.
  - o_busy = (state == RUN).
  - o_finished = (state == DONE).
- Accept: on an edge with i_start = 1 and state IDLE or DONE:
  - Capture operands.
  - Set acc ← {N'b0, i_addend}, mcand ← {N'b0, i_multiplicand}, mplier ← i_multiplier, count ← 0.
  - Go to RUN.
- RUN iteration, one per edge:
  - If mplier[0] = 1, acc ← acc + mcand (2N-bit adder).
  - mcand ← mcand << 1.
  - mplier ← mplier >> 1.
  - count ← count + 1.
- Termination: the iteration with count = N−1 also writes o_product ← the updated acc, then goes to DONE.
- DONE lasts one cycle:
  - With i_start = 1, accept (back-to-back operation).
  - Otherwise go to IDLE.
- i_start while RUN: ignored, no side effects. Operand inputs are don't-care outside the accept edge.
- Width rule: the maximum result (2^N−1)² + 2^N−1 = 2^2N − 2^N fits in 2N bits. No carry-out is kept; the adder carry out of bit 2N−1 is provably zero.
- Reset (any state, including mid-RUN) forces:
  - state IDLE, o_busy 0, o_finished 0, o_product 0.
  - acc, mcand, mplier and count cleared.
  - An in-flight operation is discarded with no finished pulse.

## Timing
- Reset values: o_busy 0, o_finished 0, o_product all zeros.
- Accept edge E0. Iterations on E1..EN.
  - o_busy is high in the cycles after E0 through E(N−1).
  - o_finished is high exactly in the cycle after EN.
  - Latency is N+1 edges from accept to finished.
- o_product changes only on the final iteration edge, so it is stable during o_finished and afterwards.
- Throughput: one operation per N+1 cycles with i_start held high.
- i_start and reset on the same edge: reset wins.

## Configuration
- MULTIPLIER_EARLY_EXIT_EN:
  - Defined: RUN also terminates on the first iteration edge where the shifted mplier becomes zero. Latency becomes max(1, k+1) + 1 edges, where k is the index of the highest set bit of i_multiplier. i_multiplier = 0 completes after one iteration. The result is identical to the undefined case.
  - Undefined: fixed N iterations regardless of operand values. count is the only termination condition.

## Test plan
- N=8, mcand 11, mplier 13, addend 7 → o_finished in the cycle after edge E8, o_product = 150, o_busy high for exactly 8 cycles.
- N=8, 255 × 255 + 255 → o_product = 65280 (0xFF00), no overflow; then 0 × 200 + 5 → 5.
- i_start held high continuously, operand pairs (3,4,1) then (6,7,0) → results 13 and 42, finishes 9 cycles apart; i_start pulses during RUN do not restart.
- Reset asserted at iteration 4 of (100,100,0) → next cycle o_busy 0, o_product 0, no o_finished pulse; a fresh request afterwards returns the correct result.
- MULTIPLIER_EARLY_EXIT_EN defined, mplier 1, mcand 9, addend 2 → o_finished after 2 edges, o_product 11. mplier 0x80 → 8 iterations. Undefined macro → 9 edges for both.
